// File: rtl/sram_dp_be_param.sv
// True dual-port SRAM with per-byte enables, 1- or 2-cycle read latency, defined
// cross-port collision behaviour and an optional zero-fill pass after reset.
module sram_dp_be_param #(
    parameter int    ADDR_W         = 12,
    parameter int    DATA_W         = 32,
    parameter string INIT_FILE      = "",
    parameter int    RD_LATENCY     = 1,
    parameter int    XPORT_MODE     = 0,
    parameter int    CLEAR_ON_RESET = 0,
    localparam int   BE_W           = DATA_W / 8
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              READY,
    input  logic              CSN1,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic              WE1,
    input  logic [BE_W-1:0]   BE1,
    input  logic [DATA_W-1:0] DI1,
    output logic [DATA_W-1:0] DO1,
    output logic              DV1,
    input  logic              CSN2,
    input  logic [ADDR_W-1:0] ADDR2,
    input  logic              WE2,
    input  logic [BE_W-1:0]   BE2,
    input  logic [DATA_W-1:0] DI2,
    output logic [DATA_W-1:0] DO2,
    output logic              DV2,
    output logic              COLL
);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_RESET;
            cnt   <= '0;
            READY <= 1'b0;
        end else begin
            case (state)
                ST_RESET: begin
                    cnt <= '0;
                    if (CLEAR_ON_RESET != 0) begin
                        state <= ST_CLEAR;
                    end else begin
                        state <= ST_RUN;
                        READY <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (&cnt) begin
                        state <= ST_RUN;
                        READY <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    READY <= 1'b1;
                end
            endcase
        end
    end

    logic acc1, acc2, wr1, wr2, rd1, rd2, clearing, coll_now;

    // RST gating keeps the array untouched on the edge that reset is applied.
    assign acc1     = READY && !RST && !CSN1;
    assign acc2     = READY && !RST && !CSN2;
    assign wr1      = acc1 && WE1;
    assign wr2      = acc2 && WE2;
    assign rd1      = acc1 && !WE1;
    assign rd2      = acc2 && !WE2;
    assign clearing = (state == ST_CLEAR) && !RST;
    assign coll_now = acc1 && acc2 && (ADDR1 == ADDR2) && (WE1 || WE2);

    logic [DATA_W-1:0] rword1, rword2;

    always_comb begin
        rword1 = mem[ADDR1];
        rword2 = mem[ADDR2];
        if (XPORT_MODE != 0 && ADDR1 == ADDR2) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr2 && BE2[i]) rword1[8*i +: 8] = DI2[8*i +: 8];
                if (wr1 && BE1[i]) rword2[8*i +: 8] = DI1[8*i +: 8];
            end
        end
    end

    // Port 2 is written last so it wins on bytes both ports enable.
    always_ff @(posedge CLK) begin
        if (clearing) mem[cnt] <= '0;
        for (int i = 0; i < BE_W; i++) begin
            if (wr1 && BE1[i]) mem[ADDR1][8*i +: 8] <= DI1[8*i +: 8];
            if (wr2 && BE2[i]) mem[ADDR2][8*i +: 8] <= DI2[8*i +: 8];
        end
    end

    logic              s1_vld, s2_vld;
    logic [BE_W-1:0]   s1_be, s2_be;
    logic [DATA_W-1:0] s1_dat, s2_dat;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s1_be  <= '0;
            s2_be  <= '0;
            s1_dat <= '0;
            s2_dat <= '0;
        end else begin
            s1_vld <= rd1;
            s2_vld <= rd2;
            s1_be  <= BE1;
            s2_be  <= BE2;
            s1_dat <= rword1;
            s2_dat <= rword2;
        end
    end

    logic              o1_vld, o2_vld;
    logic [BE_W-1:0]   o1_be, o2_be;
    logic [DATA_W-1:0] o1_dat, o2_dat;

    assign o1_vld = (RD_LATENCY == 2) ? s1_vld : rd1;
    assign o2_vld = (RD_LATENCY == 2) ? s2_vld : rd2;
    assign o1_be  = (RD_LATENCY == 2) ? s1_be  : BE1;
    assign o2_be  = (RD_LATENCY == 2) ? s2_be  : BE2;
    assign o1_dat = (RD_LATENCY == 2) ? s1_dat : rword1;
    assign o2_dat = (RD_LATENCY == 2) ? s2_dat : rword2;

    // Disabled byte lanes of DO hold whatever the last read left there.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DO1  <= '0;
            DO2  <= '0;
            DV1  <= 1'b0;
            DV2  <= 1'b0;
            COLL <= 1'b0;
        end else begin
            DV1  <= o1_vld;
            DV2  <= o2_vld;
            COLL <= coll_now;
            for (int i = 0; i < BE_W; i++) begin
                if (o1_vld && o1_be[i]) DO1[8*i +: 8] <= o1_dat[8*i +: 8];
                if (o2_vld && o2_be[i]) DO2[8*i +: 8] <= o2_dat[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_sram_dp_be_param.sv
// Drives two SRAM instances (latency 1 / old-data, latency 2 / new-data) with identical
// stimulus and checks both against a word-level memory model plus literal expectations.
module tb_sram_dp_be_param;
    localparam int AW    = 5;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          csn1, csn2, we1, we2;
    logic [AW-1:0] addr1, addr2;
    logic [3:0]    be1, be2;
    logic [31:0]   di1, di2;

    logic [1:0]       ready_o, dv1_o, dv2_o, coll_o;
    logic [1:0][31:0] do1_o, do2_o;

    always #5 clk = ~clk;

    sram_dp_be_param #(.ADDR_W(AW), .DATA_W(32), .RD_LATENCY(1), .XPORT_MODE(0), .CLEAR_ON_RESET(1)) dut_a (
        .CLK(clk), .RST(rst), .READY(ready_o[0]),
        .CSN1(csn1), .ADDR1(addr1), .WE1(we1), .BE1(be1), .DI1(di1), .DO1(do1_o[0]), .DV1(dv1_o[0]),
        .CSN2(csn2), .ADDR2(addr2), .WE2(we2), .BE2(be2), .DI2(di2), .DO2(do2_o[0]), .DV2(dv2_o[0]),
        .COLL(coll_o[0]));

    sram_dp_be_param #(.ADDR_W(AW), .DATA_W(32), .RD_LATENCY(2), .XPORT_MODE(1), .CLEAR_ON_RESET(1)) dut_b (
        .CLK(clk), .RST(rst), .READY(ready_o[1]),
        .CSN1(csn1), .ADDR1(addr1), .WE1(we1), .BE1(be1), .DI1(di1), .DO1(do1_o[1]), .DV1(dv1_o[1]),
        .CSN2(csn2), .ADDR2(addr2), .WE2(we2), .BE2(be2), .DI2(di2), .DO2(do2_o[1]), .DV2(dv2_o[1]),
        .COLL(coll_o[1]));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bemerge(input logic [31:0] cur, input logic [31:0] nw,
                                            input logic [3:0] be);
        for (int i = 0; i < 4; i++) if (be[i]) cur[8*i +: 8] = nw[8*i +: 8];
        return cur;
    endfunction

    // Model: index 0 = latency 1 / old data, index 1 = latency 2 / merged data.
    logic [31:0] m [DEPTH];
    bit          started = 1'b0;
    int          rel     = 0;
    bit          m_ready = 1'b0;
    bit          m_coll  = 1'b0;
    logic [31:0] e_do1 [2], e_do2 [2], pd1 [2], pd2 [2];
    bit          e_dv1 [2], e_dv2 [2], pv1 [2], pv2 [2];
    logic [3:0]  pb1 [2], pb2 [2];

    always @(posedge clk) begin
        logic [31:0] old1, old2, new1, new2;
        bit a1, a2;
        if (rst) begin
            started = 1'b1;
            rel     = 0;
            m_ready = 1'b0;
            m_coll  = 1'b0;
            for (int d = 0; d < 2; d++) begin
                e_do1[d] = '0; e_do2[d] = '0; e_dv1[d] = 1'b0; e_dv2[d] = 1'b0;
                pv1[d] = 1'b0; pv2[d] = 1'b0;
            end
        end else begin
            a1   = m_ready && !csn1;
            a2   = m_ready && !csn2;
            old1 = m[addr1];
            old2 = m[addr2];
            if (a1 && we1) m[addr1] = bemerge(m[addr1], di1, be1);
            if (a2 && we2) m[addr2] = bemerge(m[addr2], di2, be2);
            new1   = m[addr1];
            new2   = m[addr2];
            m_coll = a1 && a2 && (addr1 == addr2) && (we1 || we2);
            for (int d = 0; d < 2; d++) begin
                e_dv1[d] = 1'b0;
                e_dv2[d] = 1'b0;
                if (pv1[d]) begin e_do1[d] = bemerge(e_do1[d], pd1[d], pb1[d]); e_dv1[d] = 1'b1; pv1[d] = 1'b0; end
                if (pv2[d]) begin e_do2[d] = bemerge(e_do2[d], pd2[d], pb2[d]); e_dv2[d] = 1'b1; pv2[d] = 1'b0; end
                if (a1 && !we1) begin
                    if (d == 0) begin e_do1[0] = bemerge(e_do1[0], old1, be1); e_dv1[0] = 1'b1; end
                    else begin pv1[1] = 1'b1; pd1[1] = new1; pb1[1] = be1; end
                end
                if (a2 && !we2) begin
                    if (d == 0) begin e_do2[0] = bemerge(e_do2[0], old2, be2); e_dv2[0] = 1'b1; end
                    else begin pv2[1] = 1'b1; pd2[1] = new2; pb2[1] = be2; end
                end
            end
            // The array is ready DEPTH+1 edges after reset release and is all zero by then.
            if (rel <= DEPTH) rel++;
            if (rel == DEPTH + 1 && !m_ready) begin
                m_ready = 1'b1;
                for (int a = 0; a < DEPTH; a++) m[a] = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                chk1($sformatf("ready[%0d]", d), ready_o[d], m_ready);
                chk1($sformatf("coll[%0d]", d),  coll_o[d],  m_coll);
                chk1($sformatf("dv1[%0d]", d),   dv1_o[d],   e_dv1[d]);
                chk1($sformatf("dv2[%0d]", d),   dv2_o[d],   e_dv2[d]);
                chk($sformatf("do1[%0d]", d),    do1_o[d],   e_do1[d]);
                chk($sformatf("do2[%0d]", d),    do2_o[d],   e_do2[d]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        csn1 = 1'b1; csn2 = 1'b1; we1 = 1'b0; we2 = 1'b0;
        addr1 = '0; addr2 = '0; be1 = 4'h0; be2 = 4'h0; di1 = '0; di2 = '0;
    endtask

    task automatic p1(input logic w, input int a, input logic [3:0] be, input logic [31:0] d);
        csn1 = 1'b0; we1 = w; addr1 = AW'(a); be1 = be; di1 = d;
    endtask

    task automatic p2(input logic w, input int a, input logic [3:0] be, input logic [31:0] d);
        csn2 = 1'b0; we2 = w; addr2 = AW'(a); be2 = be; di2 = d;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk1("clear_ready_low", ready_o[0], 1'b0);
        end
        step();
        chk1("clear_ready_high", ready_o[0], 1'b1);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step(); step();
        chk1("rst_ready", ready_o[0], 1'b0);
        chk("rst_do1", do1_o[0], 32'h0);
        chk1("rst_dv1", dv1_o[0], 1'b0);
        rst = 1'b0;
        wait_ready();

        for (int a = 0; a < DEPTH; a++) begin p1(1'b1, a, 4'hF, 32'hFFFF_FFFF); step(); end
        idle(); p1(1'b0, 5, 4'hF, 0); step();
        chk("fill_do1", do1_o[0], 32'hFFFF_FFFF);
        idle();

        // Reset, let the clear reach cnt=8, then abort with a second reset.
        rst = 1'b1; step(); step(); rst = 1'b0;
        step();
        for (int i = 0; i < 8; i++) step();
        rst = 1'b1; step(); rst = 1'b0;
        wait_ready();
        p1(1'b0, 5, 4'hF, 0); step();
        chk("clear_do1", do1_o[0], 32'h0);
        chk1("clear_dv1", dv1_o[0], 1'b1);
        p1(1'b0, 31, 4'hF, 0); step();
        p1(1'b0, 0, 4'hF, 0); step();
        idle(); step();

        p1(1'b1, 16, 4'hF, 32'hAABB_CCDD); step();
        p1(1'b1, 16, 4'b0101, 32'h1122_3344); step();
        idle(); p2(1'b0, 16, 4'hF, 0); step();
        chk("merge_do2_a", do2_o[0], 32'hAA22_CC44);
        chk1("merge_dv2_b_early", dv2_o[1], 1'b0);
        idle(); step();
        chk("merge_do2_b", do2_o[1], 32'hAA22_CC44);
        chk1("merge_dv2_b", dv2_o[1], 1'b1);

        for (int a = 1; a <= 3; a++) begin p1(1'b1, a, 4'hF, 32'(a)); step(); end
        idle();
        for (int i = 0; i < 3; i++) begin
            p2(1'b0, i + 1, 4'hF, 0); step();
            chk("b2b_do2_a", do2_o[0], 32'(i + 1));
            if (i > 0) chk("b2b_do2_b", do2_o[1], 32'(i));
        end
        idle(); step();
        chk("b2b_do2_b_last", do2_o[1], 32'h3);
        chk1("b2b_dv2_b_last", dv2_o[1], 1'b1);
        step();
        chk1("b2b_dv2_b_end", dv2_o[1], 1'b0);
        chk("b2b_do2_b_hold", do2_o[1], 32'h3);

        p1(1'b1, 7, 4'hF, 32'h1111_1111); p2(1'b1, 7, 4'b0011, 32'h2222_2222); step();
        chk1("ww_coll_a", coll_o[0], 1'b1);
        chk1("ww_coll_b", coll_o[1], 1'b1);
        idle(); step();
        chk1("ww_coll_clr", coll_o[0], 1'b0);
        p1(1'b0, 7, 4'hF, 0); step();
        chk("ww_data", do1_o[0], 32'h1111_2222);
        idle();

        p1(1'b1, 9, 4'hF, 32'hDEAD_BEEF); p2(1'b0, 9, 4'hF, 0); step();
        chk("rw_old_a", do2_o[0], 32'h0);
        chk1("rw_coll_a", coll_o[0], 1'b1);
        idle(); step();
        chk("rw_new_b", do2_o[1], 32'hDEAD_BEEF);

        p1(1'b1, 10, 4'hF, 32'hFFFF_FFFF); p2(1'b1, 11, 4'hF, 32'h1234_5678); step();
        idle(); p1(1'b0, 10, 4'hF, 0); step();
        chk("part_pre_a", do1_o[0], 32'hFFFF_FFFF);
        p1(1'b0, 11, 4'b0011, 0); p2(1'b0, 11, 4'hF, 0); step();
        chk("part_do1_a", do1_o[0], 32'hFFFF_5678);
        chk1("rr_no_coll", coll_o[0], 1'b0);
        idle(); step();
        chk("part_do1_b", do1_o[1], 32'hFFFF_5678);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
